// File: rtl/dht11_read_scheduler.sv
// Single-shot DHT11 read sequencer: releases the sensor interface for a fixed
// window, validates the captured 40-bit frame and returns a coded response.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | ready for a command; gap counter keeps running
// GAP_WAIT | holds off until MIN_GAP_CYCLES have passed since the last read
// ACQUIRE  | sensor interface out of reset, counting the acquisition window
// CHECK    | interface back in reset; classify the captured frame
// RESPOND  | pending response is issued as a one-cycle strobe next cycle
module dht11_read_scheduler #(
    parameter int unsigned READ_WAIT_CYCLES = 2_500_000,
    parameter int unsigned MIN_GAP_CYCLES   = 100_000_000,
    parameter int unsigned CNT_W            = 27
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_cmd,
    output logic        sensor_rst_n,
    input  logic [39:0] sensor_data,
    output logic        resp_valid,
    output logic [7:0]  resp_code,
    output logic [7:0]  resp_data,
    output logic        busy
);

    localparam logic [CNT_W-1:0] GAP_MAX  = CNT_W'(MIN_GAP_CYCLES);
    localparam logic [CNT_W-1:0] WAIT_END = CNT_W'(READ_WAIT_CYCLES - 1);

    localparam logic [7:0] CMD_TEMP     = 8'h01;
    localparam logic [7:0] CMD_HUM      = 8'h02;
    localparam logic [7:0] CMD_STATUS   = 8'h03;
    localparam logic [7:0] RESP_FAULT   = 8'hE0;
    localparam logic [7:0] RESP_CSUM    = 8'hE1;
    localparam logic [7:0] RESP_INVALID = 8'hEE;

    typedef enum logic [2:0] {
        IDLE,
        GAP_WAIT,
        ACQUIRE,
        CHECK,
        RESPOND
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] gap_q;
    logic [CNT_W-1:0] wait_q;
    logic [7:0]       cmd_q;
    logic [39:0]      frame_q;
    logic [7:0]       code_q, code_d;
    logic [7:0]       data_q, data_d;
    logic [7:0]       frame_sum;
    logic             cmd_ok;

    // 8-bit context: carries out of the checksum sum are dropped
    assign frame_sum = frame_q[39:32] + frame_q[31:24] + frame_q[23:16] + frame_q[15:8];
    assign cmd_ok    = (req_cmd == CMD_TEMP) || (req_cmd == CMD_HUM) || (req_cmd == CMD_STATUS);

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (cmd_ok) begin
                        state_d = GAP_WAIT;
                    end else begin
                        state_d = RESPOND;
                        code_d  = RESP_INVALID;
                        data_d  = 8'h00;
                    end
                end
            end
            GAP_WAIT: begin
                if (gap_q == GAP_MAX) state_d = ACQUIRE;
            end
            ACQUIRE: begin
                if (wait_q == WAIT_END) state_d = CHECK;
            end
            CHECK: begin
                state_d = RESPOND;
                if ((frame_q == 40'hFF_FFFF_FFFF) || (frame_q == 40'h0)) begin
                    code_d = RESP_FAULT;
                    data_d = 8'hFF;
                end else if (frame_q[7:0] != frame_sum) begin
                    code_d = RESP_CSUM;
                    data_d = frame_q[7:0];
                end else if (cmd_q == CMD_TEMP) begin
                    code_d = CMD_TEMP;
                    data_d = frame_q[23:16];
                end else if (cmd_q == CMD_HUM) begin
                    code_d = CMD_HUM;
                    data_d = frame_q[39:32];
                end else begin
                    code_d = CMD_STATUS;
                    data_d = 8'h00;
                end
            end
            RESPOND: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            gap_q        <= '0;
            wait_q       <= '0;
            cmd_q        <= 8'h00;
            frame_q      <= 40'h0;
            code_q       <= 8'h00;
            data_q       <= 8'h00;
            sensor_rst_n <= 1'b0;
            resp_valid   <= 1'b0;
            resp_code    <= 8'h00;
            resp_data    <= 8'h00;
        end else begin
            state_q      <= state_d;
            code_q       <= code_d;
            data_q       <= data_d;
            sensor_rst_n <= (state_d == ACQUIRE);

            // gap restarts on the edge that releases the sensor interface
            if ((state_q == GAP_WAIT) && (state_d == ACQUIRE)) begin
                gap_q <= '0;
            end else if (gap_q != GAP_MAX) begin
                gap_q <= gap_q + CNT_W'(1);
            end

            if (state_q == ACQUIRE) begin
                wait_q <= wait_q + CNT_W'(1);
            end else begin
                wait_q <= '0;
            end

            if ((state_q == IDLE) && req_valid) begin
                cmd_q <= req_cmd;
            end

            if ((state_q == ACQUIRE) && (state_d == CHECK)) begin
                frame_q <= sensor_data;
            end

            resp_valid <= (state_q == RESPOND);
            if (state_q == RESPOND) begin
                resp_code <= code_q;
                resp_data <= data_q;
            end
        end
    end

endmodule

// File: tb/tb_dht11_read_scheduler.sv
// Bench for dht11_read_scheduler: a timeline model of each command is checked
// against the DUT every cycle, plus literal checks on key latencies and responses.
module tb_dht11_read_scheduler;

    localparam int RW = 50;
    localparam int MG = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_cmd = 8'h00;
    logic        sensor_rst_n;
    logic [39:0] sensor_data;
    logic        resp_valid;
    logic [7:0]  resp_code;
    logic [7:0]  resp_data;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [39:0] frame_cfg = 40'h37_00_19_00_50;
    logic        drive_en  = 1'b1;

    always #5 clk = ~clk;

    // sensor interface model: output only while released from reset
    assign sensor_data = (sensor_rst_n && drive_en) ? frame_cfg : 40'h0;

    dht11_read_scheduler #(
        .READ_WAIT_CYCLES(RW),
        .MIN_GAP_CYCLES  (MG),
        .CNT_W           (27)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_cmd     (req_cmd),
        .sensor_rst_n(sensor_rst_n),
        .sensor_data (sensor_data),
        .resp_valid  (resp_valid),
        .resp_code   (resp_code),
        .resp_data   (resp_data),
        .busy        (busy)
    );

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void classify(input logic [7:0] cmd, input logic [39:0] f,
                                     output logic [7:0] c, output logic [7:0] d);
        logic [7:0] sum;
        sum = f[39:32] + f[31:24] + f[23:16] + f[15:8];
        if (f == 40'hFF_FFFF_FFFF || f == 40'h0) begin c = 8'hE0; d = 8'hFF; end
        else if (f[7:0] != sum)                   begin c = 8'hE1; d = f[7:0]; end
        else if (cmd == 8'h01)                    begin c = 8'h01; d = f[23:16]; end
        else if (cmd == 8'h02)                    begin c = 8'h02; d = f[39:32]; end
        else                                      begin c = 8'h03; d = 8'h00; end
    endfunction

    // Timeline model: n counts clock edges since reset release. Each accepted
    // command gets its rise/fall/response edges computed up front.
    int         n = 0;
    int         last_clear = 0;
    bit         txn = 1'b0;
    int         t_acc = -1, t_rise = -1, t_fall = -1, t_resp = -1;
    logic [7:0] t_code = 8'h00, t_data = 8'h00;
    logic [7:0] m_code = 8'h00, m_data = 8'h00;
    bit         m_busy_prev;

    always @(posedge clk) begin
        if (rst) begin
            n = 0; last_clear = 0; txn = 1'b0; m_code = 8'h00; m_data = 8'h00;
        end else begin
            m_busy_prev = txn && (n >= t_acc) && (n < t_resp);
            n = n + 1;
            if (!m_busy_prev && req_valid) begin
                t_acc = n;
                if (req_cmd == 8'h01 || req_cmd == 8'h02 || req_cmd == 8'h03) begin
                    t_rise = (n + 1 > last_clear + MG + 1) ? n + 1 : last_clear + MG + 1;
                    t_fall = t_rise + RW;
                    t_resp = t_fall + 2;
                    last_clear = t_rise;
                    classify(req_cmd, drive_en ? frame_cfg : 40'h0, t_code, t_data);
                end else begin
                    t_rise = -1; t_fall = -1; t_resp = n + 1;
                    t_code = 8'hEE; t_data = 8'h00;
                end
                txn = 1'b1;
            end
            if (txn && n == t_resp) begin
                m_code = t_code; m_data = t_data;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check_val("sensor_rst_n", sensor_rst_n, txn && n >= t_rise && n < t_fall);
            check_val("resp_valid", resp_valid, txn && n == t_resp);
            check_val("busy", busy, txn && n >= t_acc && n < t_resp);
            check_val("req_ready", req_ready, !(txn && n >= t_acc && n < t_resp));
            check_val("resp_code", resp_code, m_code);
            check_val("resp_data", resp_data, m_data);
        end
    end

    // rise/width monitor and accept counter
    logic srn_prev = 1'b0;
    int   last_rise = -1, prev_rise = -1, last_width = -1;
    int   acc_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            srn_prev = 1'b0; last_rise = -1; prev_rise = -1;
        end else begin
            if (sensor_rst_n && !srn_prev) begin prev_rise = last_rise; last_rise = n; end
            if (!sensor_rst_n && srn_prev) last_width = n - last_rise;
            srn_prev = sensor_rst_n;
        end
    end

    always @(posedge clk) if (!rst && req_valid && req_ready) acc_cnt++;

    task automatic issue(input logic [7:0] cmd, output int acc);
        acc = -1;
        req_cmd = cmd;
        req_valid = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            if (req_ready) begin
                @(posedge clk);
                @(negedge clk);
                acc = n;
                req_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        checks++; errors++;
        $display("FAIL accept_timeout: req_ready never high, expected accept within 2000 cycles");
    endtask

    task automatic wait_resp(input int budget, output int r_edge, output logic [7:0] c, output logic [7:0] d);
        r_edge = -1; c = 8'h00; d = 8'h00;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (resp_valid) begin r_edge = n; c = resp_code; d = resp_data; return; end
        end
        checks++; errors++;
        $display("FAIL resp_timeout: no resp_valid in %0d cycles, expected one strobe", budget);
    endtask

    task automatic do_read(input string tag, input logic [7:0] cmd, input logic [7:0] ec,
                           input logic [7:0] ed, output int acc, output int r_edge);
        logic [7:0] c, d;
        issue(cmd, acc);
        wait_resp(800, r_edge, c, d);
        check_val({tag, "_code"}, c, ec);
        check_val({tag, "_data"}, d, ed);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, re;
        logic [7:0] c, d;

        repeat (3) @(negedge clk);
        #1;
        check_val("rst_req_ready", req_ready, 1'b1);
        check_val("rst_sensor_rst_n", sensor_rst_n, 1'b0);
        check_val("rst_resp_valid", resp_valid, 1'b0);
        check_val("rst_resp_code", resp_code, 8'h00);
        check_val("rst_resp_data", resp_data, 8'h00);
        check_val("rst_busy", busy, 1'b0);
        @(negedge clk); #2 rst = 1'b0;
        @(negedge clk);

        // invalid code: first edge sampling the strobe is 2 after accept
        do_read("invalid", 8'h7A, 8'hEE, 8'h00, acc, re);
        check_val("invalid_latency", re + 1 - acc, 2);

        // gap reaches 200 on edge 200, GAP_WAIT releases the interface on edge 201
        do_read("temp", 8'h01, 8'h01, 8'h19, acc, re);
        check_val("first_rise_edge", last_rise, 201);
        check_val("first_width", last_width, 50);

        do_read("hum", 8'h02, 8'h02, 8'h37, acc, re);
        check_val("gap_ok", (last_rise - prev_rise) >= MG, 1'b1);
        check_val("gap_exact", last_rise - prev_rise, 201);
        check_val("hum_width", last_width, 50);

        // saturated gap: 1 + RW + 1 + 1 edges to the strobe
        frame_cfg = 40'h37_00_19_00_51;
        repeat (250) @(negedge clk);
        do_read("csum", 8'h01, 8'hE1, 8'h51, acc, re);
        check_val("sat_latency", re - acc, 53);

        frame_cfg = 40'hFF_FFFF_FFFF;
        do_read("ones", 8'h02, 8'hE0, 8'hFF, acc, re);

        // FF+FF+02+00 = 0x200 wraps to 0x00
        frame_cfg = 40'hFF_FF_02_00_00;
        do_read("wrap", 8'h01, 8'h01, 8'h02, acc, re);

        drive_en = 1'b0;
        do_read("nodrive", 8'h01, 8'hE0, 8'hFF, acc, re);
        drive_en = 1'b1;
        frame_cfg = 40'h37_00_19_00_50;

        // reset 20 cycles into ACQUIRE
        issue(8'h01, acc);
        begin
            bit seen;
            seen = 1'b0;
            for (int k = 0; k < 600 && !seen; k++) begin
                @(negedge clk);
                if (sensor_rst_n) seen = 1'b1;
            end
            check_val("acq_started", seen, 1'b1);
        end
        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_val("midrst_sensor_rst_n", sensor_rst_n, 1'b0);
        check_val("midrst_resp_valid", resp_valid, 1'b0);
        check_val("midrst_req_ready", req_ready, 1'b1);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        do_read("status", 8'h03, 8'h03, 8'h00, acc, re);
        check_val("post_rst_rise_edge", last_rise, 201);

        // held req_valid with back-to-back status commands
        acc_cnt = 0;
        req_cmd = 8'h03;
        req_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_resp(800, re, c, d);
            check_val("b2b_code", c, 8'h03);
            check_val("b2b_data", d, 8'h00);
        end
        req_valid = 1'b0;
        check_val("b2b_accepts", acc_cnt, 3);
        check_val("b2b_gap", last_rise - prev_rise, 201);

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
